// File: rtl/instruction_fetch_pkg.sv
// Shared processor constants and the fetch FSM state encoding.
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP    = 32'd4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_adder.sv
// PC incrementer: o_adder = i_adder + PC_STEP, wrapping modulo 2^N_BITS.
module instruction_fetch_adder
    import instruction_fetch_pkg::*;
#(
    parameter int N_BITS = 32
) (
    input  logic [N_BITS-1:0] i_adder,
    output logic [N_BITS-1:0] o_adder
);

    assign o_adder = i_adder + N_BITS'(PC_STEP);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, branch/jump redirect, IF/ID latch,
// debug step mode and a RUN/HALTED FSM that stops on the halt word.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                N_BITS   = 32,
    parameter logic [N_BITS-1:0] PC_RESET = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_step_mode,
    input  logic              i_step,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [N_BITS-1:0] i_branch_target,
    input  logic              i_jump,
    input  logic [N_BITS-1:0] i_jump_target,
    input  logic [N_BITS-1:0] i_imem_data,
    output logic [N_BITS-1:0] o_pc,
    output logic [N_BITS-1:0] o_if_id_pc4,
    output logic [N_BITS-1:0] o_if_id_instr,
    output logic              o_if_id_valid,
    output logic              o_halted,
    output logic [N_BITS-1:0] o_fetch_count
);

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [N_BITS-1:0] r_pc;
    logic [N_BITS-1:0] r_if_id_pc4;
    logic [N_BITS-1:0] r_if_id_instr;
    logic              r_if_id_valid;
    logic [N_BITS-1:0] r_fetch_count;

    logic [N_BITS-1:0] w_pc4;
    logic [N_BITS-1:0] w_next_pc;
    logic              w_adv;
    logic              w_redirect;
    logic              w_halt_fetch;

    instruction_fetch_adder #(
        .N_BITS (N_BITS)
    ) u_pc_adder (
        .i_adder (r_pc),
        .o_adder (w_pc4)
    );

    assign w_adv        = (r_state == ST_RUN) && !i_stall && (!i_step_mode || i_step);
    assign w_redirect   = i_branch_taken || i_jump;
    assign w_halt_fetch = w_adv && !w_redirect && (i_imem_data == N_BITS'(HALT_INSTR));

    // Branch outranks jump; redirect targets are forced word-aligned.
    always_comb begin
        w_next_pc = w_pc4;
        if (i_branch_taken) begin
            w_next_pc = {i_branch_target[N_BITS-1:2], 2'b00};
        end else if (i_jump) begin
            w_next_pc = {i_jump_target[N_BITS-1:2], 2'b00};
        end
    end

    always_comb begin
        // NOTE: default assigned first so every path drives w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ST_RUN:    if (w_halt_fetch) w_next_state = ST_HALTED;
            ST_HALTED: w_next_state = ST_HALTED;
            default:   w_next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (i_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc          <= PC_RESET;
            r_if_id_pc4   <= '0;
            r_if_id_instr <= '0;
            r_if_id_valid <= 1'b0;
            r_fetch_count <= '0;
        end else if (w_adv) begin
            if (w_redirect) begin
                // A redirect squashes the word fetched this cycle into a bubble.
                r_pc          <= w_next_pc;
                r_if_id_pc4   <= '0;
                r_if_id_instr <= N_BITS'(NOP_INSTR);
                r_if_id_valid <= 1'b0;
            end else begin
                r_pc          <= w_halt_fetch ? r_pc : w_next_pc;
                r_if_id_pc4   <= w_pc4;
                r_if_id_instr <= i_imem_data;
                r_if_id_valid <= 1'b1;
                r_fetch_count <= r_fetch_count + 1'b1;
            end
        end
    end

    assign o_pc          = r_pc;
    assign o_if_id_pc4   = r_if_id_pc4;
    assign o_if_id_instr = r_if_id_instr;
    assign o_if_id_valid = r_if_id_valid;
    assign o_halted      = (r_state == ST_HALTED);
    assign o_fetch_count = r_fetch_count;

endmodule
